// File: rtl/instr_pkg.sv
// Shared ISA constants and encode helpers for the instruction encoder.
// The mnemonic list is the request code space; the opcodes and field positions define the ISA word.
package instr_pkg;

  localparam logic [4:0] MN_ADD  = 5'd0,  MN_SUB  = 5'd1,  MN_AND  = 5'd2,  MN_OR   = 5'd3;
  localparam logic [4:0] MN_SLL  = 5'd4,  MN_SRA  = 5'd5,  MN_MUL  = 5'd6,  MN_DIV  = 5'd7;
  localparam logic [4:0] MN_J    = 5'd8,  MN_BNE  = 5'd9,  MN_JAL  = 5'd10, MN_JR   = 5'd11;
  localparam logic [4:0] MN_ADDI = 5'd12, MN_BLT  = 5'd13, MN_SW   = 5'd14, MN_LW   = 5'd15;
  localparam logic [4:0] MN_SETX = 5'd16, MN_BEX  = 5'd17;

  localparam logic [4:0] OP_RTYPE = 5'b00000, OP_J    = 5'b00001, OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL   = 5'b00011, OP_JR   = 5'b00100, OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110, OP_SW   = 5'b00111, OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX  = 5'b10101, OP_BEX  = 5'b10110;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_AND = 5'd2, ALU_OR  = 5'd3;
  localparam logic [4:0] ALU_SLL = 5'd4, ALU_SRA = 5'd5, ALU_MUL = 5'd6, ALU_DIV = 5'd7;

  localparam int OPCODE_LSB = 27;
  localparam int RD_LSB     = 22;
  localparam int RS_LSB     = 17;
  localparam int RT_LSB     = 12;
  localparam int SHAMT_LSB  = 7;
  localparam int ALUOP_LSB  = 2;
  localparam int IMM_W      = 17;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_FLUSH = 2'd2, ST_DONE = 2'd3} state_t;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_JR, FMT_JI} fmt_t;

  typedef struct packed {
    logic [4:0]  mnem;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  shamt;
    logic [26:0] imm;
  } req_t;

  function automatic fmt_t fmt_of(input logic [4:0] mnem);
    case (mnem)
      MN_ADDI, MN_SW, MN_LW, MN_BNE, MN_BLT: return FMT_I;
      MN_JR:                                 return FMT_JR;
      MN_J, MN_JAL, MN_SETX, MN_BEX:         return FMT_JI;
      default:                               return FMT_R;
    endcase
  endfunction

  function automatic logic [4:0] opcode_of(input logic [4:0] mnem);
    case (mnem)
      MN_J:    return OP_J;
      MN_BNE:  return OP_BNE;
      MN_JAL:  return OP_JAL;
      MN_JR:   return OP_JR;
      MN_ADDI: return OP_ADDI;
      MN_BLT:  return OP_BLT;
      MN_SW:   return OP_SW;
      MN_LW:   return OP_LW;
      MN_SETX: return OP_SETX;
      MN_BEX:  return OP_BEX;
      default: return OP_RTYPE;
    endcase
  endfunction

  function automatic logic [4:0] aluop_of(input logic [4:0] mnem);
    case (mnem)
      MN_SUB:  return ALU_SUB;
      MN_AND:  return ALU_AND;
      MN_OR:   return ALU_OR;
      MN_SLL:  return ALU_SLL;
      MN_SRA:  return ALU_SRA;
      MN_MUL:  return ALU_MUL;
      MN_DIV:  return ALU_DIV;
      default: return ALU_ADD;
    endcase
  endfunction

  // A 17-bit immediate field can only hold values whose upper bits are pure sign extension.
  function automatic logic imm_fits(input logic [26:0] imm);
    return (imm[26:16] == '0) || (imm[26:16] == '1);
  endfunction

  function automatic logic is_legal(input req_t r);
    if (r.mnem > MN_BEX) return 1'b0;
    if (fmt_of(r.mnem) == FMT_I) return imm_fits(r.imm);
    return 1'b1;
  endfunction

  function automatic logic [31:0] encode(input req_t r);
    logic [31:0] w;
    w = 32'(opcode_of(r.mnem)) << OPCODE_LSB;
    case (fmt_of(r.mnem))
      FMT_R:  w = w | (32'(r.rd) << RD_LSB) | (32'(r.rs) << RS_LSB) | (32'(r.rt) << RT_LSB)
                    | (32'(r.shamt) << SHAMT_LSB) | (32'(aluop_of(r.mnem)) << ALUOP_LSB);
      FMT_I:  w = w | (32'(r.rd) << RD_LSB) | (32'(r.rs) << RS_LSB) | 32'(r.imm[IMM_W-1:0]);
      FMT_JR: w = w | (32'(r.rd) << RD_LSB);
      default: w = w | 32'(r.imm);
    endcase
    return w;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake plus imem write bus of the instruction encoder.
interface instr_encoder_if #(parameter int ADDR_W = 12);
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_mnem;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs;
  logic [4:0]        in_rt;
  logic [4:0]        in_shamt;
  logic [26:0]       in_imm;
  logic              imem_wren;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;

  modport master (
    output in_valid, in_mnem, in_rd, in_rs, in_rt, in_shamt, in_imm,
    input  in_ready, imem_wren, imem_addr, imem_data
  );

  modport slave (
    input  in_valid, in_mnem, in_rd, in_rs, in_rt, in_shamt, in_imm,
    output in_ready, imem_wren, imem_addr, imem_data
  );
endinterface

// File: rtl/instr_fifo.sv
// Synchronous FIFO between the encode stage and the imem writer; show-ahead read data.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop & ~empty;
  // A full FIFO still takes a push when the same cycle frees a slot.
  assign wr_en = push & (~full | rd_en);
  assign rdata = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes mnemonic requests into ISA words and streams them into imem at consecutive addresses.
module instr_encoder import instr_pkg::*; #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic              done,
  output logic [ADDR_W:0]   words_written,
  output logic              err_illegal,
  output logic              err_wrap
);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_t                state, state_nx;
  logic                  ready, pop, load;
  logic                  fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;
  logic [31:0]           fifo_rdata;

  req_t                  req_p0;
  logic [31:0]           word_p0;
  logic                  legal_p0, acc_p0, vld_p0;

  logic [ADDR_W-1:0]     addr_ptr;
  logic                  wren_p1;
  logic [ADDR_W-1:0]     addr_p1;
  logic [31:0]           data_p1;

  // Stage p0: encode the presented request
  assign req_p0   = {bus.in_mnem, bus.in_rd, bus.in_rs, bus.in_rt, bus.in_shamt, bus.in_imm};
  assign word_p0  = encode(req_p0);
  assign legal_p0 = is_legal(req_p0);
  assign acc_p0   = bus.in_valid & ready;
  assign vld_p0   = acc_p0 & legal_p0;

  instr_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (vld_p0),
    .wdata (word_p0),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = ST_RUN;
      ST_RUN:           if (finish) state_nx = ST_FLUSH;
      ST_FLUSH:         if (fifo_count == '0 && !wren_p1) state_nx = ST_DONE;
      default:          state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    ready = (state == ST_RUN) && !fifo_full;
    pop   = ((state == ST_RUN) || (state == ST_FLUSH)) && !fifo_empty;
    load  = ((state == ST_IDLE) || (state == ST_DONE)) && start;
    done  = (state == ST_DONE);
  end

  // Stage p1: registered imem write, one strobe per popped word
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_ptr      <= '0;
      wren_p1       <= 1'b0;
      addr_p1       <= '0;
      data_p1       <= '0;
      words_written <= '0;
      err_illegal   <= 1'b0;
      err_wrap      <= 1'b0;
    end else begin
      wren_p1 <= pop;
      if (load) begin
        addr_ptr      <= base_addr;
        words_written <= '0;
        err_illegal   <= 1'b0;
        err_wrap      <= 1'b0;
      end else begin
        if (acc_p0 && !legal_p0) err_illegal <= 1'b1;
        if (pop) begin
          addr_p1       <= addr_ptr;
          data_p1       <= fifo_rdata;
          addr_ptr      <= addr_ptr + 1'b1;
          words_written <= words_written + 1'b1;
          if (addr_ptr == ADDR_MAX) err_wrap <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.imem_wren = wren_p1;
  assign bus.imem_addr = addr_p1;
  assign bus.imem_data = data_p1;

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the processor's instruction decode. Turns structured mnemonic/field requests into 32-bit ISA words and streams them into instruction memory at consecutive addresses.
- Used by the bench/boot loader to build programs in imem without hand-assembled hex.
- Pipeline: encode stage, then a small sync FIFO, then an imem writer under a run/flush FSM.

Parameters:
- ADDR_W, 12, imem word-address width.
- DEPTH, 4, FIFO entries (power of 2, ≥2).

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- start, input, 1, pulse: load base_addr, enter RUN.
- finish, input, 1, pulse: no more requests; drain, then DONE.
- base_addr, input, ADDR_W, first imem address.
- in_valid, input, 1, request valid.
- in_ready, output, 1, request accepted when in_valid & in_ready at the edge.
- in_mnem, input, 5, mnemonic code (package list).
- in_rd, input, 5, rd field.
- in_rs, input, 5, rs field.
- in_rt, input, 5, rt field.
- in_shamt, input, 5, shift amount.
- in_imm, input, 27, immediate (sign-extended) or jump target.
- imem_wren, output, 1, imem write strobe.
- imem_addr, output, ADDR_W, write address.
- imem_data, output, 32, encoded word.
- done, output, 1, high while in DONE.
- words_written, output, ADDR_W+1, count of words written since start.
- err_illegal, output, 1, sticky: bad mnemonic or immediate overflow.
- err_wrap, output, 1, sticky: address wrapped past 2^ADDR_W-1.

Behaviour:
- Reset: state IDLE, FIFO empty, all outputs 0 (in_ready, imem_wren, imem_addr, imem_data, done, words_written, both err flags).
- Mnemonic codes: 0 add, 1 sub, 2 and, 3 or, 4 sll, 5 sra, 6 mul, 7 div, 8 j, 9 bne, 10 jal, 11 jr, 12 addi, 13 blt, 14 sw, 15 lw, 16 setx, 17 bex. Codes 18–31 are illegal.
- Opcode [31:27] per mnemonic:
  - R-type (add through div) 00000, with ALU op [6:2] = mnemonic code.
  - j 00001, bne 00010, jal 00011, jr 00100, addi 00101, blt 00110, sw 00111, lw 01000, setx 10101, bex 10110.
- Field layout:
  - R-type: rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], [1:0]=0.
  - I-type (addi, sw, lw, bne, blt): rd[26:22], rs[21:17], imm[16:0] = in_imm[16:0].
  - jr: rd[26:22], all other bits 0.
  - JI-type (j, jal, setx, bex): target[26:0] = in_imm.
- Immediate overflow: for I-type, in_imm[26:16] must be all 0s or all 1s; otherwise it is illegal.
- Illegal request: still accepted (handshake completes), word discarded (not pushed), err_illegal set.
- FSM:
  - IDLE: on start, load addr_ptr = base_addr, clear words_written and the err flags, go to RUN.
  - RUN: in_ready = ~fifo_full. On finish, go to FLUSH.
  - FLUSH: in_ready = 0. When the FIFO is empty and no write is in flight, go to DONE.
  - DONE: done = 1. On start, reload and go to RUN.
  - start outside IDLE/DONE is ignored; finish outside RUN is ignored.
- Latency:
  - A request accepted at edge k is in the FIFO after edge k.
  - Writer pops at edge k+1 and registers imem_wren = 1 with addr/data. That set of outputs is valid for exactly one cycle.
  - Sustained throughput: 1 word/cycle.
- Writer (RUN or FLUSH, FIFO non-empty):
  - Each cycle: pop, write to addr_ptr, then addr_ptr+1 and words_written+1.
  - imem_wren = 0 otherwise; imem_addr/imem_data hold their last value.
- Simultaneous push and pop when full: allowed; count is unchanged. in_ready is based on the registered count, so no push occurs while full.
- Wrap: addr_ptr increments modulo 2^ADDR_W. A write at 2^ADDR_W-1 sets err_wrap; writing continues at address 0.
- reset mid-operation: immediate return to reset state. Queued words are lost; no further writes.

Decomposition:
- Package instr_pkg:
  - opcode localparams (OP_RTYPE … OP_BEX), ALU op constants, mnemonic codes.
  - FSM state encoding (2-bit: IDLE/RUN/FLUSH/DONE).
  - field bit-position constants.
- One sub-module, instr_fifo: sync FIFO with DEPTH and 32-bit width; push/pop/full/empty/count. Encode logic and FSM stay in the top.

Test Plan:
- start, base_addr=0x010; addi rd=1 rs=0 imm=5 -> imem_wren at addr 0x010, data 0x28400005, two edges after accept.
- mul rd=3 rs=1 rt=2, then jr rd=31, back-to-back -> 0x00C22018 @0x010, 0x27C00000 @0x011 on consecutive cycles; words_written=2.
- sw rd=2 rs=1 imm=27'h7FFFFFF; setx imm=7 -> 0x3883FFFF, then 0xA8000007.
- Illegal cases: addi imm=0x10000 (overflow) and in_mnem=20 -> no write for either, err_illegal=1, handshake completes, next legal word lands at the next sequential address.
- Hold imem writes off (start not yet given, requests pre-presented) and burst DEPTH+2 requests after start -> in_ready never accepts while full, no word lost or reordered. finish mid-burst -> all queued words written, then done=1 and in_ready=0.
- ADDR_W=4, base_addr=0xE, 3 words -> addresses 0xE, 0xF, 0x0, err_wrap=1. Assert reset with the FIFO non-empty -> next cycle imem_wren=0, all outputs 0, state IDLE.
